mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master Wishbone arbiter that shares the single master port of the memory bus switch between the CPU bus interface unit (master 0) and a second memory master such as a DMA or VGA frame fetcher (master 1). It sits between those masters and the memory bus switch, which is unchanged. The arbiter grants one master at a time with round-robin fairness and holds the grant until the slave acknowledges. A watchdog ends any transaction that receives no ack, so a dead slave cannot hang the CPU.

## Interface
Parameters:
- TIMEOUT, default 1023: cycles in BUSY without ack before the watchdog fires (1..2^CNT_W-1).
- CNT_W, default 10: watchdog counter width.

Ports (clock and reset first):
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  reset; asynchronous, active-high.
- m0_stb_i, m1_stb_i  in  1  master request strobes.
- m0_we_i, m1_we_i  in  1  write enables.
- m0_adr_i, m1_adr_i  in  32  addresses.
- m0_dat_i, m1_dat_i  in  32  write data.
- m0_sel_i, m1_sel_i  in  4  byte selects.
- m0_dat_o, m1_dat_o  out  32  read data, driven from s_dat_i to both masters.
- m0_ack_o, m1_ack_o  out  1  ack, routed only to the owning master.
- m0_err_o, m1_err_o  out  1  one-cycle timeout error pulse to the owner.
- s_stb_o, s_we_o  out  1  slave-side strobe and write enable.
- s_adr_o, s_dat_o  out  32  slave-side address and write data.
- s_sel_o  out  4  slave-side byte selects.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- owner_o  out  1  current or last owner (0 = master 0, 1 = master 1).
- busy_o  out  1  high while in BUSY.
- timeout_cnt_o  out  8  saturating count of watchdog events.

## Operation
- FSM states are IDLE and BUSY. The owner, last-granted and counter registers are all internal.
- IDLE with no request: stay in IDLE.
- IDLE with exactly one stb high: grant that master on the next edge and go to BUSY.
- IDLE with both stb high: grant the master that is not last_grant (round-robin); last_grant updates on every grant.
- BUSY, slave-side outputs:
  - s_stb_o = owner's stb_i; this is combinational, so a master that drops stb aborts cleanly.
  - s_we_o, s_adr_o, s_dat_o and s_sel_o are muxed combinationally from the owner.
- BUSY, master-side outputs:
  - mX_ack_o = s_ack_i & (owner == X) & s_stb_o. The non-owner never sees ack.
  - m0_dat_o and m1_dat_o both equal s_dat_i at all times.
- BUSY exit:
  - On s_ack_i, or when the owner's stb drops, return to IDLE on the next edge.
  - The watchdog clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches TIMEOUT: pulse mX_err_o for one cycle for the owner, increment timeout_cnt_o (saturating at 255), and go to IDLE.
- Back-to-back requests: after an ack there is always one IDLE cycle before the next grant. This gives 1 dead cycle, which also lets a pipelined master drop stb.
- When not BUSY, all slave-side outputs are 0.

## Timing
- Reset (asynchronous, immediate): state = IDLE, owner_o = 0, last_grant = 1 (so master 0 wins the first tie), busy_o = 0, timeout_cnt_o = 0. s_stb_o, all acks and all errs are 0.
  - Reset mid-transaction drops s_stb_o in the same cycle, with no ack or err.
- Grant latency: stb high at edge N while IDLE → busy_o and s_stb_o high after edge N (visible in cycle N+1).
- Ack path: s_ack_i to mX_ack_o is zero-latency combinational.
- Error pulse: the err pulse is registered and appears in the first IDLE cycle after the timeout.
- Simultaneous events:
  - Ack and timeout in the same cycle: ack wins, no err, no count.
  - Stb drop and timeout in the same cycle: no err.
- Timeout boundary: TIMEOUT = 1 means err if ack is not in the first BUSY cycle.
- Both masters requesting continuously: grants strictly alternate 0,1,0,1…

## Test plan
- Single master: m0 reads with the slave acking in the 2nd BUSY cycle → s_stb_o high one cycle after the m0 request; m0_ack_o high once and m1_ack_o stays 0; busy_o falls next cycle.
- Tie after reset: m0 and m1 assert stb at the same edge → m0 granted first, then m1 after one IDLE cycle. Repeat 4 times with both held → owner sequence 0,1,0,1.
- Timeout: TIMEOUT = 8, slave never acks → exactly 8 BUSY cycles, one m1_err_o pulse, timeout_cnt_o = 1. Repeat 300 times → timeout_cnt_o saturates at 255.
- Ack on the timeout cycle (ack in BUSY cycle 8 with TIMEOUT = 8) → ack delivered, no err, timeout_cnt_o unchanged.
- Master abort: m1 drops stb in BUSY before ack → s_stb_o falls the same cycle, IDLE next edge, no ack or err.
- Reset mid-transaction: assert rst_i while BUSY with stb high → s_stb_o, busy_o and owner_o go to 0 asynchronously; after release, a pending m1 request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held until ack, with a
// watchdog that ends transactions the slave never acknowledges.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic        owner_o,
    output logic        busy_o,
    output logic [7:0]  timeout_cnt_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic             m0_err_q, m0_err_d;
    logic             m1_err_q, m1_err_d;

    logic             busy;
    logic             owner_stb;
    logic             timeout_hit;
    logic             grant;

    assign busy        = (state_q == StBusy);
    assign owner_stb   = owner_q ? m1_stb_i : m0_stb_i;
    // Last BUSY cycle the watchdog allows; ack or a dropped strobe take priority.
    assign timeout_hit = busy && owner_stb && !s_ack_i &&
                         (wd_cnt_q == CNT_W'(TIMEOUT - 1));

    assign m0_dat_o      = s_dat_i;
    assign m1_dat_o      = s_dat_i;
    assign owner_o       = owner_q;
    assign busy_o        = busy;
    assign timeout_cnt_o = timeout_cnt_q;
    assign m0_err_o      = m0_err_q;
    assign m1_err_o      = m1_err_q;

    // Slave-side mux from the owner; everything is forced low outside BUSY.
    always_comb begin
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        if (busy) begin
            s_stb_o = owner_stb;
            s_we_o  = owner_q ? m1_we_i  : m0_we_i;
            s_adr_o = owner_q ? m1_adr_i : m0_adr_i;
            s_dat_o = owner_q ? m1_dat_i : m0_dat_i;
            s_sel_o = owner_q ? m1_sel_i : m0_sel_i;
        end
    end

    // Ack goes only to the owner, and only while its strobe reaches the slave.
    always_comb begin
        m0_ack_o = s_ack_i && s_stb_o && !owner_q;
        m1_ack_o = s_ack_i && s_stb_o && owner_q;
    end

    // Next-state logic: grant selection, BUSY exit and watchdog.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        m0_err_d      = 1'b0;
        m1_err_d      = 1'b0;
        grant         = (m0_stb_i && m1_stb_i) ? ~last_grant_q : m1_stb_i;

        unique case (state_q)
            StIdle: begin
                if (m0_stb_i || m1_stb_i) begin
                    state_d      = StBusy;
                    owner_d      = grant;
                    last_grant_d = grant;
                    wd_cnt_d     = '0;
                end
            end
            StBusy: begin
                if (s_ack_i || !owner_stb) begin
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    state_d  = StIdle;
                    m0_err_d = !owner_q;
                    m1_err_d = owner_q;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            wd_cnt_q      <= '0;
            timeout_cnt_q <= 8'd0;
            m0_err_q      <= 1'b0;
            m1_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            m0_err_q      <= m0_err_d;
            m1_err_q      <= m1_err_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_stb = 1'b0, m1_stb = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b1;
    logic [31:0] m0_adr = 32'h1000_0000, m1_adr = 32'h2000_0040;
    logic [31:0] m0_dat = 32'hA0A0_0001, m1_dat = 32'hB1B1_0002;
    logic [3:0]  m0_sel = 4'hF, m1_sel = 4'h3;
    logic [31:0] s_dat = 32'hDEAD_BEEF;
    logic        s_ack = 1'b0;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic        s_stb_o, s_we_o, owner_o, busy_o;
    logic [3:0]  s_sel_o;
    logic [7:0]  timeout_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter #(.TIMEOUT(TMO), .CNT_W(10)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m1_stb_i(m1_stb),
        .m0_we_i(m0_we), .m1_we_i(m1_we),
        .m0_adr_i(m0_adr), .m1_adr_i(m1_adr),
        .m0_dat_i(m0_dat), .m1_dat_i(m1_dat),
        .m0_sel_i(m0_sel), .m1_sel_i(m1_sel),
        .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
        .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: busy flag, owner, BUSY cycles elapsed, pending err, event count.
    bit m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1, m_e0 = 1'b0, m_e1 = 1'b0;
    int m_age = 0, m_tc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_age = 0; m_e0 = 0; m_e1 = 0; m_tc = 0;
        end else begin
            m_e0 = 0;
            m_e1 = 0;
            if (!m_busy) begin
                if (m0_stb || m1_stb) begin
                    m_owner = (m0_stb && m1_stb) ? !m_last : m1_stb;
                    m_last  = m_owner;
                    m_busy  = 1;
                    m_age   = 0;
                end
            end else begin
                m_age++;
                if (s_ack || !(m_owner ? m1_stb : m0_stb)) begin
                    m_busy = 0;
                end else if (m_age == TMO) begin
                    m_busy = 0;
                    if (m_owner) m_e1 = 1; else m_e0 = 1;
                    if (m_tc < 255) m_tc++;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic ostb, estb;
        ostb = m_owner ? m1_stb : m0_stb;
        estb = m_busy && ostb;
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("owner_o", 32'(owner_o), 32'(m_owner));
        chk("s_stb_o", 32'(s_stb_o), 32'(estb));
        chk("s_we_o", 32'(s_we_o), m_busy ? 32'(m_owner ? m1_we : m0_we) : 32'd0);
        chk("s_adr_o", s_adr_o, m_busy ? (m_owner ? m1_adr : m0_adr) : 32'd0);
        chk("s_dat_o", s_dat_o, m_busy ? (m_owner ? m1_dat : m0_dat) : 32'd0);
        chk("s_sel_o", 32'(s_sel_o), m_busy ? 32'(m_owner ? m1_sel : m0_sel) : 32'd0);
        chk("m0_ack_o", 32'(m0_ack_o), 32'(estb && s_ack && !m_owner));
        chk("m1_ack_o", 32'(m1_ack_o), 32'(estb && s_ack && m_owner));
        chk("m0_err_o", 32'(m0_err_o), 32'(m_e0));
        chk("m1_err_o", 32'(m1_err_o), 32'(m_e1));
        chk("timeout_cnt_o", 32'(timeout_cnt_o), 32'(m_tc));
        chk("m0_dat_o", m0_dat_o, s_dat);
        chk("m1_dat_o", m1_dat_o, s_dat);
    end

    // Log the owner at every rising edge of busy_o.
    int grants[$];
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (busy_o && !prev_busy) grants.push_back(32'(owner_o));
        prev_busy = busy_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // m1 request with a silent slave; returns BUSY length and err pulses seen.
    task automatic run_timeout(output int nbusy, output int nerr);
        nbusy = 0;
        nerr  = 0;
        m1_stb = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m1_err_o) nerr++;
            if (!busy_o) break;
            nbusy++;
        end
        m1_stb = 1'b0;
        tick();
    endtask

    initial begin
        int nb, ne;

        tick();
        tick();
        chk("reset busy_o", 32'(busy_o), 32'd0);
        chk("reset owner_o", 32'(owner_o), 32'd0);
        chk("reset timeout_cnt_o", 32'(timeout_cnt_o), 32'd0);
        chk("reset s_stb_o", 32'(s_stb_o), 32'd0);
        rst = 1'b0;

        // Single master read, ack in the second BUSY cycle.
        m0_stb = 1'b1;
        tick();
        chk("t1 s_stb_o", 32'(s_stb_o), 32'd1);
        chk("t1 s_adr_o", s_adr_o, 32'h1000_0000);
        tick();
        s_ack = 1'b1;
        s_dat = 32'h1234_5678;
        #1;
        chk("t1 m0_ack_o", 32'(m0_ack_o), 32'd1);
        chk("t1 m1_ack_o", 32'(m1_ack_o), 32'd0);
        chk("t1 m0_dat_o", m0_dat_o, 32'h1234_5678);
        tick();
        s_ack = 1'b0;
        m0_stb = 1'b0;
        chk("t1 busy falls", 32'(busy_o), 32'd0);
        tick();

        // Tie after reset, both held: owners alternate starting with m0.
        do_reset();
        grants.delete();
        m0_stb = 1'b1;
        m1_stb = 1'b1;
        s_ack  = 1'b1;
        repeat (8) tick();
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        s_ack  = 1'b0;
        chk("t2 grant count", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            chk("t2 grant0", 32'(grants[0]), 32'd0);
            chk("t2 grant1", 32'(grants[1]), 32'd1);
            chk("t2 grant2", 32'(grants[2]), 32'd0);
            chk("t2 grant3", 32'(grants[3]), 32'd1);
        end
        tick();

        // Timeout with a silent slave.
        run_timeout(nb, ne);
        chk("t3 busy cycles", 32'(nb), 32'd8);
        chk("t3 m1_err pulses", 32'(ne), 32'd1);
        chk("t3 timeout_cnt_o", 32'(timeout_cnt_o), 32'd1);

        // Ack on the timeout cycle wins: no err, count unchanged.
        m0_stb = 1'b1;
        repeat (8) tick();
        s_ack = 1'b1;
        #1;
        chk("t4 busy in cycle 8", 32'(busy_o), 32'd1);
        chk("t4 m0_ack_o", 32'(m0_ack_o), 32'd1);
        tick();
        s_ack = 1'b0;
        m0_stb = 1'b0;
        chk("t4 m0_err_o", 32'(m0_err_o), 32'd0);
        chk("t4 timeout_cnt_o", 32'(timeout_cnt_o), 32'd1);
        tick();

        // 299 more timeouts (300 total) saturate the event counter.
        repeat (299) run_timeout(nb, ne);
        chk("t3 saturated", 32'(timeout_cnt_o), 32'd255);

        // Master abort: stb drop kills s_stb_o in the same cycle.
        m1_stb = 1'b1;
        tick();
        tick();
        m1_stb = 1'b0;
        #1;
        chk("t5 s_stb_o drop", 32'(s_stb_o), 32'd0);
        tick();
        chk("t5 busy_o", 32'(busy_o), 32'd0);
        chk("t5 m1_err_o", 32'(m1_err_o), 32'd0);
        tick();

        // Reset mid-transaction, then the pending m1 request is granted.
        m1_stb = 1'b1;
        tick();
        chk("t6 owner before", 32'(owner_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6 s_stb_o async", 32'(s_stb_o), 32'd0);
        chk("t6 busy_o async", 32'(busy_o), 32'd0);
        chk("t6 owner_o async", 32'(owner_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6 regrant busy", 32'(busy_o), 32'd1);
        chk("t6 regrant owner", 32'(owner_o), 32'd1);
        s_ack = 1'b1;
        #1;
        chk("t6 m1_ack_o", 32'(m1_ack_o), 32'd1);
        tick();
        s_ack = 1'b0;
        m1_stb = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
